mem_req_scheduler: RTL and testbench
====================================

// Module: mem_req_scheduler
// PURPOSE
//  Arbitrates the single byte-serial memory port between instruction line refill (IFU/icache miss) and
//  load/store requests (LSB); issues one command at a time to the memory unit and routes its completion
//  back to the winning requester. Sits between IFU/LSB and the memory unit's command interface.
//  Adds IO-write back-pressure (uart full), an ifetch anti-starvation counter and flush cancellation.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive ifetch losses to LSB before ifetch is forced to win
//  CNT_W         3   width of starvation counter (must hold STARVE_LIMIT)
//  POS_W         4   width of LSB entry index (LSB_CAP_BIT)
// PORTS
//  clk_in          in   1      system clock
//  rst_in          in   1      asynchronous, active-low reset
//  rdy_in          in   1      global ready; low = freeze all state
//  io_buffer_full  in   1      uart buffer full
//  flush           in   1      mispredict flush; cancels ifetch traffic
//  if_req          in   1      ifetch line refill request (level, held until if_done)
//  if_addr         in   32     line-aligned fetch address
//  if_done         out  1      1-cycle pulse: line written into icache
//  ls_req          in   1      LSB request (level, held until ls_done)
//  ls_we           in   1      1 = store
//  ls_size         in   2      0 byte, 1 half, 2 word
//  ls_addr         in   32     data address
//  ls_wdata        in   32     store data
//  ls_pos          in   POS_W  LSB entry index
//  ls_done         out  1      1-cycle pulse: access finished
//  ls_done_pos     out  POS_W  entry index for ls_done
//  mu_valid        out  1      1-cycle command strobe to memory unit
//  mu_type         out  1      0 ifetch, 1 data
//  mu_addr         out  32     command address
//  mu_we, mu_size  out  1, 2   command write flag / size
//  mu_wdata        out  32     command store data
//  mu_pos          out  POS_W  command LSB index
//  mu_done         in   1      1-cycle completion pulse from memory unit
// BEHAVIOUR
//  Reset (rst_in=0, async): state=IDLE, starve_cnt=0, all outputs 0, kill flag 0.
//  rdy_in=0: no state, counter or output register changes; mu_done arriving then is held until rdy_in=1.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE: eligible_ls = ls_req && !(ls_we && ls_addr[17:16]==2'b11 && io_buffer_full);
//         eligible_if = if_req && !flush. Winner chosen:
//         - starve_cnt==STARVE_LIMIT and eligible_if -> ifetch;
//         - else eligible_ls -> LSB; else eligible_if -> ifetch; else stay IDLE.
//         Winner fields latched into mu_* registers; go ISSUE.
//   ISSUE: mu_valid=1 for exactly this cycle; go WAIT.
//   WAIT: mu_valid=0, mu_* fields held stable; on mu_done -> IDLE, same edge registers the done pulse.
//  Latency: request seen in IDLE at cycle N -> mu_valid at N+1; done pulse in cycle after mu_done.
//  Done routing: mu_type=1 -> ls_done=1, ls_done_pos=latched pos; mu_type=0 -> if_done=1 unless killed.
//  Starvation: starve_cnt++ (saturating) when LSB wins while eligible_if; cleared when ifetch wins;
//   unchanged when no contention.
//  IO blocking: a blocked IO store never issues; ifetch may win meanwhile; re-evaluated each IDLE cycle.
//   IO loads are never blocked.
//  Flush: in IDLE, suppresses ifetch eligibility that cycle. Flush in ISSUE/WAIT with mu_type=0 sets
//   kill; transaction still runs to mu_done (memory unit not abortable) but if_done is suppressed; kill
//   clears on return to IDLE. Flush never affects in-flight data commands.
//  Simultaneous flush and mu_done in WAIT on ifetch: if_done suppressed.
//  Only one command outstanding ever; mu_done outside WAIT is ignored.
//  Reset mid-transaction: FSM to IDLE immediately; no done pulse is produced afterwards.
// TESTING
//  1 if_req only, addr 0x100; mu_done 4 cycles after mu_valid -> mu_valid 1 cycle after req, type 0,
//    addr 0x100; if_done 1 cycle after mu_done.
//  2 if_req+ls_req (load 0x200, pos 3) same cycle -> LSB first; ls_done_pos=3; then ifetch issued.
//  3 ls_req held continuously with if_req, STARVE_LIMIT=4 -> 4 data cmds, 5th command is ifetch, cnt=0.
//  4 store to 0x30000 with io_buffer_full=1 and if_req -> ifetch issued, store held; full drops ->
//    store issued next IDLE cycle.
//  5 flush during WAIT of ifetch -> mu_done accepted, if_done stays 0, FSM back to IDLE.
//  6 rst_in low in WAIT; rdy_in low with mu_done -> outputs 0 at once; with rdy low, done deferred.

Source files
------------

// File: rtl/mem_req_scheduler.sv
// Memory command scheduler: arbitrates ifetch line refills against LSB accesses
// for the single byte-serial memory unit, keeping one command outstanding at a time.
module mem_req_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3,
    parameter int POS_W        = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             io_buffer_full,
    input  logic             flush,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_done,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [1:0]       ls_size,
    input  logic [31:0]      ls_addr,
    input  logic [31:0]      ls_wdata,
    input  logic [POS_W-1:0] ls_pos,
    output logic             ls_done,
    output logic [POS_W-1:0] ls_done_pos,
    output logic             mu_valid,
    output logic             mu_type,
    output logic [31:0]      mu_addr,
    output logic             mu_we,
    output logic [1:0]       mu_size,
    output logic [31:0]      mu_wdata,
    output logic [POS_W-1:0] mu_pos,
    input  logic             mu_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             kill_q;
    logic             done_pend_q;
    logic             io_blocked;
    logic             elig_ls;
    logic             elig_if;
    logic             pick_if;
    logic             pick_ls;
    logic             done_now;
    logic             flush_if;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= LIMIT) ? LIMIT : v + CNT_W'(1);
    endfunction

    // Stores into the uart window (addr[17:16]==3) wait while its buffer is full.
    always_comb begin
        io_blocked = ls_we && (ls_addr[17:16] == 2'b11) && io_buffer_full;
        elig_ls    = ls_req && !io_blocked;
        elig_if    = if_req && !flush;
        pick_if    = elig_if && ((starve_cnt == LIMIT) || !elig_ls);
        pick_ls    = elig_ls && !pick_if;
        done_now   = mu_done || done_pend_q;
        flush_if   = flush && !mu_type;
        state_d    = state_q;
        case (state_q)
            S_IDLE:  if (pick_if || pick_ls) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (done_now) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mu_valid    <= 1'b0;
            mu_type     <= 1'b0;
            mu_addr     <= '0;
            mu_we       <= 1'b0;
            mu_size     <= '0;
            mu_wdata    <= '0;
            mu_pos      <= '0;
            if_done     <= 1'b0;
            ls_done     <= 1'b0;
            ls_done_pos <= '0;
            starve_cnt  <= '0;
            kill_q      <= 1'b0;
            done_pend_q <= 1'b0;
        end else if (!rdy_in) begin
            // Frozen, but a completion must not be lost while the core stalls.
            if (state_q == S_WAIT && mu_done) done_pend_q <= 1'b1;
        end else begin
            mu_valid <= 1'b0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    kill_q      <= 1'b0;
                    done_pend_q <= 1'b0;
                    if (pick_if) begin
                        mu_valid   <= 1'b1;
                        mu_type    <= 1'b0;
                        mu_addr    <= if_addr;
                        mu_we      <= 1'b0;
                        mu_size    <= '0;
                        mu_wdata   <= '0;
                        mu_pos     <= '0;
                        starve_cnt <= '0;
                    end else if (pick_ls) begin
                        mu_valid <= 1'b1;
                        mu_type  <= 1'b1;
                        mu_addr  <= ls_addr;
                        mu_we    <= ls_we;
                        mu_size  <= ls_size;
                        mu_wdata <= ls_wdata;
                        mu_pos   <= ls_pos;
                        if (elig_if) starve_cnt <= sat_inc(starve_cnt);
                    end
                end
                S_ISSUE: begin
                    if (flush_if) kill_q <= 1'b1;
                end
                S_WAIT: begin
                    // The memory unit cannot abort, so a flushed fetch still waits for mu_done.
                    if (done_now) begin
                        kill_q      <= 1'b0;
                        done_pend_q <= 1'b0;
                        if (mu_type) begin
                            ls_done     <= 1'b1;
                            ls_done_pos <= mu_pos;
                        end else begin
                            if_done <= !(kill_q || flush);
                        end
                    end else if (flush_if) begin
                        kill_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Bench for mem_req_scheduler: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_mem_req_scheduler;
    localparam int STARVE_LIMIT = 4;
    localparam int POS_W        = 4;

    logic             clk_in;
    logic             rst_in;
    logic             rdy_in;
    logic             io_buffer_full;
    logic             flush;
    logic             if_req;
    logic [31:0]      if_addr;
    logic             if_done;
    logic             ls_req;
    logic             ls_we;
    logic [1:0]       ls_size;
    logic [31:0]      ls_addr;
    logic [31:0]      ls_wdata;
    logic [POS_W-1:0] ls_pos;
    logic             ls_done;
    logic [POS_W-1:0] ls_done_pos;
    logic             mu_valid;
    logic             mu_type;
    logic [31:0]      mu_addr;
    logic             mu_we;
    logic [1:0]       mu_size;
    logic [31:0]      mu_wdata;
    logic [POS_W-1:0] mu_pos;
    logic             mu_done;

    mem_req_scheduler #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3), .POS_W(POS_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
        .flush(flush), .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_pos(ls_pos), .ls_done(ls_done), .ls_done_pos(ls_done_pos),
        .mu_valid(mu_valid), .mu_type(mu_type), .mu_addr(mu_addr), .mu_we(mu_we),
        .mu_size(mu_size), .mu_wdata(mu_wdata), .mu_pos(mu_pos), .mu_done(mu_done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks;
    int errors;

    // Reference model: one outstanding command, its fields, and completion bookkeeping.
    bit               m_busy, m_issue, m_kill, m_pend;
    int               m_losses;
    bit               e_valid, e_type, e_we, e_if_done, e_ls_done;
    logic [31:0]      e_addr, e_wdata;
    logic [1:0]       e_size;
    logic [POS_W-1:0] e_pos, e_done_pos;

    // Memory-unit responder and agent controls.
    bit r_busy, force_done, spurious, rand_mode, ls_keep;
    int r_wait, r_target, fixed_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_issue = 0; m_kill = 0; m_pend = 0; m_losses = 0;
        e_valid = 0; e_type = 0; e_we = 0; e_if_done = 0; e_ls_done = 0;
        e_addr = 0; e_wdata = 0; e_size = 0; e_pos = 0; e_done_pos = 0;
    endtask

    task automatic model_step();
        bit want_ls, want_if;
        if (!rst_in) begin
            model_reset();
            return;
        end
        if (!rdy_in) begin
            if (m_busy && !m_issue && mu_done) m_pend = 1;
            return;
        end
        e_valid = 0; e_if_done = 0; e_ls_done = 0;
        if (!m_busy) begin
            want_ls = ls_req && !(ls_we && ls_addr[17:16] == 2'b11 && io_buffer_full);
            want_if = if_req && !flush;
            if (want_if && (m_losses >= STARVE_LIMIT || !want_ls)) begin
                m_busy = 1; m_issue = 1; e_valid = 1; e_type = 0;
                e_addr = if_addr; e_we = 0; e_size = 0; e_wdata = 0; e_pos = 0;
                m_losses = 0;
            end else if (want_ls) begin
                m_busy = 1; m_issue = 1; e_valid = 1; e_type = 1;
                e_addr = ls_addr; e_we = ls_we; e_size = ls_size; e_wdata = ls_wdata; e_pos = ls_pos;
                if (want_if && m_losses < STARVE_LIMIT) m_losses++;
            end
        end else if (m_issue) begin
            m_issue = 0;
            if (flush && !e_type) m_kill = 1;
        end else begin
            if (flush && !e_type) m_kill = 1;
            if (mu_done || m_pend) begin
                if (e_type) begin
                    e_ls_done = 1; e_done_pos = e_pos;
                end else begin
                    e_if_done = !m_kill;
                end
                m_busy = 0; m_kill = 0; m_pend = 0;
            end
        end
    endtask

    task automatic compare();
        chk("mu_valid", 32'(mu_valid), 32'(e_valid));
        chk("mu_type", 32'(mu_type), 32'(e_type));
        chk("mu_addr", mu_addr, e_addr);
        chk("mu_we", 32'(mu_we), 32'(e_we));
        if (e_type) begin
            chk("mu_size", 32'(mu_size), 32'(e_size));
            chk("mu_wdata", mu_wdata, e_wdata);
            chk("mu_pos", 32'(mu_pos), 32'(e_pos));
        end
        chk("if_done", 32'(if_done), 32'(e_if_done));
        chk("ls_done", 32'(ls_done), 32'(e_ls_done));
        chk("ls_done_pos", 32'(ls_done_pos), 32'(e_done_pos));
    endtask

    task automatic responder();
        mu_done = 0;
        if (!rst_in) begin
            r_busy = 0;
            return;
        end
        if (force_done) begin
            mu_done = 1; force_done = 0;
            return;
        end
        if (!r_busy) begin
            if (mu_valid) begin
                r_busy = 1; r_wait = 0;
                r_target = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            end else if (spurious && $urandom_range(0, 19) == 0) begin
                mu_done = 1;
            end
        end else if (!mu_valid) begin
            r_wait++;
            if (r_wait >= r_target) begin
                mu_done = 1; r_busy = 0;
            end
        end
    endtask

    task automatic agents();
        if (if_done && if_req) if_req = 0;
        if (ls_done && ls_req) begin
            if (ls_keep) begin
                ls_pos = ls_pos + 1'b1; ls_addr = ls_addr + 32'd4;
            end else begin
                ls_req = 0;
            end
        end
        if (rand_mode) begin
            if (!if_req && !if_done && $urandom_range(0, 3) == 0) begin
                if_req = 1; if_addr = $urandom() & 32'hFFFF_FFC0;
            end
            if (!ls_req && !ls_done && $urandom_range(0, 2) == 0) begin
                ls_req = 1; ls_we = 1'($urandom()); ls_size = 2'($urandom_range(0, 2));
                ls_addr = ($urandom_range(0, 2) == 0) ? {14'd0, 2'b11, 16'($urandom())}
                                                      : ($urandom() & 32'h0000_FFFC);
                ls_wdata = $urandom(); ls_pos = POS_W'($urandom());
            end
            flush = ($urandom_range(0, 9) == 0);
            if (flush && $urandom_range(0, 1) == 0) if_addr = $urandom() & 32'hFFFF_FFC0;
            if ($urandom_range(0, 7) == 0) io_buffer_full = ~io_buffer_full;
            rdy_in = ($urandom_range(0, 7) != 0);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        model_step();
        #1;
        responder();
        agents();
        @(negedge clk_in);
        compare();
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            cycle();
            ok = !m_busy && !if_req && !ls_req;
        end
        chk("drain_idle", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst_in = 0;
        model_reset();
        r_busy = 0;
        mu_done = 0;
        #1;
        compare();
    endtask

    initial begin
        int n, got, ncmd, nvalid, nmud, ndone;
        bit [0:0] types [5];
        checks = 0; errors = 0;
        rst_in = 1; rdy_in = 1; io_buffer_full = 0; flush = 0;
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_size = 0;
        ls_addr = 0; ls_wdata = 0; ls_pos = 0; mu_done = 0;
        r_busy = 0; force_done = 0; spurious = 0; rand_mode = 0; ls_keep = 0;
        r_wait = 0; r_target = 0; fixed_lat = 4;
        model_reset();
        #2;
        do_reset();
        repeat (2) cycle();
        chk("rst_mu_valid", 32'(mu_valid), 32'd0);
        chk("rst_mu_addr", mu_addr, 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_ls_done_pos", 32'(ls_done_pos), 32'd0);
        rst_in = 1;
        cycle();

        // 1: lone ifetch, memory latency 4
        if_addr = 32'h100; if_req = 1;
        cycle();
        chk("t1_valid", 32'(mu_valid), 32'd1);
        chk("t1_type", 32'(mu_type), 32'd0);
        chk("t1_addr", mu_addr, 32'h100);
        n = 0; got = 0;
        for (int i = 0; i < 12 && got == 0; i++) begin
            cycle(); n++;
            if (if_done) got = 1;
        end
        chk("t1_if_done_latency", 32'(n), 32'd5);
        drain();

        // 2: simultaneous requests, LSB first
        if_addr = 32'h140; if_req = 1;
        ls_req = 1; ls_we = 0; ls_size = 2; ls_addr = 32'h200; ls_pos = 3; ls_wdata = 0;
        cycle();
        chk("t2_first_type", 32'(mu_type), 32'd1);
        chk("t2_first_addr", mu_addr, 32'h200);
        got = 0;
        for (int i = 0; i < 12 && got == 0; i++) begin
            cycle();
            if (ls_done) begin
                got = 1;
                chk("t2_done_pos", 32'(ls_done_pos), 32'd3);
            end
        end
        chk("t2_ls_done_seen", 32'(got), 32'd1);
        got = 0;
        for (int i = 0; i < 6 && got == 0; i++) begin
            cycle();
            if (mu_valid) begin
                got = 1;
                chk("t2_second_type", 32'(mu_type), 32'd0);
                chk("t2_second_addr", mu_addr, 32'h140);
            end
        end
        chk("t2_ifetch_seen", 32'(got), 32'd1);
        drain();

        // 3: continuous LSB traffic against a waiting ifetch
        fixed_lat = 2;
        if_addr = 32'h180; if_req = 1;
        ls_req = 1; ls_we = 0; ls_size = 2; ls_addr = 32'h400; ls_pos = 0; ls_keep = 1;
        ncmd = 0;
        for (int i = 0; i < 100 && ncmd < 5; i++) begin
            cycle();
            if (mu_valid) begin
                types[ncmd] = mu_type; ncmd++;
            end
        end
        ls_keep = 0;
        chk("t3_cmd_count", 32'(ncmd), 32'd5);
        for (int k = 0; k < 5; k++) chk("t3_cmd_type", 32'(types[k]), (k < 4) ? 32'd1 : 32'd0);
        drain();

        // 4: IO store held off by full uart buffer
        io_buffer_full = 1;
        ls_req = 1; ls_we = 1; ls_size = 2; ls_addr = 32'h30000; ls_wdata = 32'hDEADBEEF; ls_pos = 5;
        if_addr = 32'h1C0; if_req = 1;
        cycle();
        chk("t4_if_first", 32'(mu_type), 32'd0);
        chk("t4_if_addr", mu_addr, 32'h1C0);
        for (int i = 0; i < 12 && if_req; i++) cycle();
        nvalid = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (mu_valid) nvalid++;
        end
        chk("t4_store_blocked", 32'(nvalid), 32'd0);
        io_buffer_full = 0;
        cycle();
        chk("t4_store_valid", 32'(mu_valid), 32'd1);
        chk("t4_store_addr", mu_addr, 32'h30000);
        chk("t4_store_we", 32'(mu_we), 32'd1);
        chk("t4_store_wdata", mu_wdata, 32'hDEADBEEF);
        drain();

        // 5: flush while the ifetch is in flight
        fixed_lat = 4;
        if_addr = 32'h240; if_req = 1;
        cycle();
        cycle();
        flush = 1; if_req = 0;
        cycle();
        flush = 0;
        ndone = 0; nmud = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (if_done) ndone++;
            if (mu_done) nmud++;
        end
        chk("t5_if_done_killed", 32'(ndone), 32'd0);
        chk("t5_mu_done_seen", 32'(nmud), 32'd1);
        ls_req = 1; ls_we = 0; ls_size = 0; ls_addr = 32'h500; ls_pos = 7;
        cycle();
        chk("t5_back_idle", 32'(mu_valid), 32'd1);
        drain();

        // 6a: reset in the middle of a fetch
        if_addr = 32'h280; if_req = 1;
        cycle();
        cycle();
        if_req = 0;
        do_reset();
        chk("t6_rst_addr", mu_addr, 32'd0);
        chk("t6_rst_type", 32'(mu_type), 32'd0);
        cycle();
        rst_in = 1;
        force_done = 1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (if_done || ls_done || mu_valid) ndone++;
        end
        chk("t6_no_done_after_rst", 32'(ndone), 32'd0);

        // 6b: completion arriving while rdy_in is low is deferred
        fixed_lat = 2;
        if_addr = 32'h2C0; if_req = 1;
        cycle();
        cycle();
        rdy_in = 0;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (if_done) ndone++;
        end
        chk("t6_done_deferred", 32'(ndone), 32'd0);
        rdy_in = 1;
        cycle();
        chk("t6_done_after_rdy", 32'(if_done), 32'd1);
        drain();

        // Random traffic
        rand_mode = 1; spurious = 1; fixed_lat = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                cycle();
                rst_in = 1;
            end
            cycle();
        end
        rand_mode = 0; spurious = 0; rdy_in = 1; flush = 0; io_buffer_full = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
